addsub4_serial_unit: RTL and testbench
======================================

# addsub4_serial_unit

- Bit-serial add/subtract engine with a valid/ready request port and a valid/ready response port.
- Accepts one operand pair plus an add/subtract select per request.
- Computes the result one bit per clock, LSB first, using a single full-adder slice and a carry flip-flop.
- Holds the result until the consumer takes it; it is the responder for the combinational `addSub4` stimulus stream, trading area for latency.

## Interface
- WIDTH, 4: operand and result width in bits (≥2)
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- av  in  WIDTH  operand A, sampled on request handshake
- bv  in  WIDTH  operand B, sampled on request handshake
- M  in  1  0 = A+B, 1 = A−B (A + ~B + 1), sampled on handshake
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- resultv  out  WIDTH  sum/difference modulo 2^WIDTH
- cout  out  1  carry out of MSB; for subtract, 1 = no borrow
- ovf  out  1  signed overflow (present only with ADDSUB_OVF_EN)

## Operation
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch av, bv and M; load carry with M; clear bit index; go to CALC.
  - CALC: each cycle, bit i = a[i] ^ (b[i]^M) ^ carry; carry ← majority of the three; i++. After bit WIDTH−1, go to DONE.
  - DONE: rsp_valid=1. On rsp_ready, go to IDLE.
- resultv is assembled in a shift register; it is invisible until DONE (outputs show the previous result, or 0 after reset).
- cout = final carry. ovf = carry into MSB XOR carry out of MSB.
- All arithmetic is unsigned, modulo 2^WIDTH. Inputs beyond WIDTH bits do not exist; the bench truncates.
- Simultaneous events:
  - req_valid in any state but IDLE is ignored; the request is not latched.
  - Operand changes after the handshake have no effect.
- Reset (any time, including mid-CALC or DONE):
  - state returns to IDLE; the in-flight operation is discarded.
  - req_ready=1, rsp_valid=0, resultv=0, cout=0, ovf=0, internal carry/index/shift register 0.

## Timing
- Handshake at edge E0 → CALC for edges E1..E_WIDTH. rsp_valid rises after edge E_WIDTH, i.e. WIDTH cycles after acceptance.
- Response handshake at the first edge where rsp_valid&&rsp_ready; req_ready rises after that edge.
- Back-to-back throughput with rsp_ready tied high: one operation per WIDTH+2 cycles (6 for WIDTH=4).
- resultv, cout and ovf are registered. They are stable for the whole time rsp_valid is high, regardless of rsp_ready stalls.
- No combinational path from any input to any output.

## Configuration
- ADDSUB_OVF_EN defined:
  - ovf port exists.
  - Overflow flip-flop is computed and captured at the transition to DONE.
- ADDSUB_OVF_EN undefined:
  - no ovf port and no overflow logic.
  - all other behaviour and timing are identical.

## Test plan
- Add, WIDTH=4: av=11, bv=15, M=0, rsp_ready=1 → rsp_valid 4 cycles after handshake; resultv=10 (1010), cout=1, ovf=0.
- Subtract, no borrow: av=8, bv=4, M=1 → resultv=4, cout=1. Subtract with borrow: av=3, bv=5, M=1 → resultv=14 (1110), cout=0, ovf=0.
- Signed overflow (ADDSUB_OVF_EN): av=7, bv=1, M=0 → resultv=8, cout=0, ovf=1. Also av=8, bv=1, M=1 → resultv=7, ovf=1.
- Backpressure: hold rsp_ready=0 for 3 cycles in DONE → resultv/cout stable, req_ready=0, new req_valid ignored; raise rsp_ready → req_ready=1 the next cycle.
- Reset mid-operation: assert reset (low) 2 cycles into CALC → outputs immediately 0, req_ready=1. After release, a new request av=2, bv=2, M=0 → resultv=4, cout=0.
- Throughput: 4 consecutive requests with req_valid and rsp_ready held high → accepts spaced exactly 6 cycles apart; every response correct.

Source files
------------

// File: rtl/addsub4_serial_unit.sv
`default_nettype none
// ============================================================================
//  Module      : addsub4_serial_unit
//  Description : Bit-serial add/subtract engine. One operand pair plus an
//                add/subtract select is accepted per request. The result is
//                computed LSB first, one bit per clock, through a single
//                full-adder slice and a carry flip-flop, then held on the
//                response port until the consumer takes it.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      operand / result width in bits (>= 2)
//  Ports
//    clk        in   1      clock, rising edge
//    reset      in   1      asynchronous, active-low reset
//    req_valid  in   1      request present
//    req_ready  out  1      unit can accept a request (idle only)
//    av         in   WIDTH  operand A, sampled on request handshake
//    bv         in   WIDTH  operand B, sampled on request handshake
//    M          in   1      0 = A+B, 1 = A-B (A + ~B + 1)
//    rsp_valid  out  1      result available
//    rsp_ready  in   1      consumer takes result
//    resultv    out  WIDTH  sum/difference modulo 2^WIDTH
//    cout       out  1      carry out of MSB (subtract: 1 = no borrow)
//    ovf        out  1      signed overflow (only with ADDSUB_OVF_EN)
//  Build option
//    ADDSUB_OVF_EN  adds the ovf port and the signed-overflow flip-flop
// ============================================================================
module addsub4_serial_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] av,
  input  logic [WIDTH-1:0] bv,
  input  logic             M,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] resultv,
  output logic             cout
`ifdef ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int IW = $clog2(WIDTH);

  localparam logic [1:0]    c_idle = 2'd0;
  localparam logic [1:0]    c_calc = 2'd1;
  localparam logic [1:0]    c_done = 2'd2;
  localparam logic [IW-1:0] c_last = IW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;       // operand A, shifted right each CALC cycle
  logic [WIDTH-1:0] r_b;       // operand B, shifted right each CALC cycle
  logic             r_m;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_sh;      // result bits assembled so far
  logic [WIDTH-1:0] r_result;  // visible result, updated only on entry to DONE
  logic             r_cout;
`ifdef ADDSUB_OVF_EN
  logic             r_ovf;
  logic             w_ovf;
`endif

  logic             w_bi;
  logic             w_sum;
  logic             w_cnext;
  logic [WIDTH-1:0] w_sh_next;

  // Single full-adder slice; B is inverted for subtract, and the +1 comes
  // from the carry being preloaded with M at acceptance.
  assign w_bi    = r_b[0] ^ r_m;
  assign w_sum   = r_a[0] ^ w_bi ^ r_carry;
  assign w_cnext = (r_a[0] & w_bi) | (r_a[0] & r_carry) | (w_bi & r_carry);

`ifdef ADDSUB_OVF_EN
  // On the last slice r_carry is the carry into the MSB.
  assign w_ovf = r_carry ^ w_cnext;
`endif

  always_comb begin
    w_sh_next        = r_sh;
    w_sh_next[r_idx] = w_sum;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= c_idle;
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= 1'b0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_sh     <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
`ifdef ADDSUB_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_idle: begin
          if (req_valid) begin
            r_a     <= av;
            r_b     <= bv;
            r_m     <= M;
            r_carry <= M;
            r_idx   <= '0;
            r_sh    <= '0;
            r_state <= c_calc;
          end
        end
        c_calc: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_cnext;
          r_sh    <= w_sh_next;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == c_last) begin
            r_result <= w_sh_next;
            r_cout   <= w_cnext;
`ifdef ADDSUB_OVF_EN
            r_ovf    <= w_ovf;
`endif
            r_state  <= c_done;
          end
        end
        c_done: begin
          if (rsp_ready) begin
            r_state <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign req_ready = (r_state == c_idle);
  assign rsp_valid = (r_state == c_done);
  assign resultv   = r_result;
  assign cout      = r_cout;
`ifdef ADDSUB_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_addsub4_serial_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub4_serial_unit
//  Description : Directed self-checking bench for addsub4_serial_unit
//                (WIDTH = 4). Expected values are hand-computed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub4_serial_unit;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] av;
  logic [WIDTH-1:0] bv;
  logic             M;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] resultv;
  logic             cout;
`ifdef ADDSUB_OVF_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  addsub4_serial_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .av        (av),
    .bv        (bv),
    .M         (M),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .resultv   (resultv),
    .cout      (cout)
`ifdef ADDSUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input int e_res, input int e_cout, input int e_ovf);
    check({tag, ".resultv"}, int'(resultv), e_res);
    check({tag, ".cout"}, int'(cout), e_cout);
`ifdef ADDSUB_OVF_EN
    check({tag, ".ovf"}, int'(ovf), e_ovf);
`else
    if (e_ovf < 0) $display("note: negative ovf expectation in %s", tag);
`endif
  endtask

  // Single operation: handshake, latency check, result check, response.
  // Operands are scrambled right after acceptance; they must not matter.
  task automatic do_op(input string tag, input int a, input int b, input int m,
                       input int e_res, input int e_cout, input int e_ovf);
    int k;
    check({tag, ".req_ready"}, int'(req_ready), 1);
    av = WIDTH'(a); bv = WIDTH'(b); M = m[0]; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; av = ~av; bv = ~bv; M = ~M;
    for (k = 1; k <= 20; k++) begin
      tick();
      if (rsp_valid) break;
    end
    check({tag, ".latency"}, k, WIDTH);
    check_flags(tag, e_res, e_cout, e_ovf);
    tick();
    check({tag, ".req_ready_after"}, int'(req_ready), 1);
  endtask

  logic [3:0] tv_a [4] = '{4'd1, 4'd12, 4'd6, 4'd4};
  logic [3:0] tv_b [4] = '{4'd2, 4'd5,  4'd6, 4'd9};
  logic       tv_m [4] = '{1'b0, 1'b1,  1'b0, 1'b1};
  int         tv_r [4] = '{3, 7, 12, 11};
  int         tv_c [4] = '{0, 1, 0, 0};
  int         tv_o [4] = '{0, 1, 1, 1};

  initial begin
    int idx, resp, last_acc;
    logic accept;

    reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    av = '0; bv = '0; M = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;

    // Reset state
    check("rst.req_ready", int'(req_ready), 1);
    check("rst.rsp_valid", int'(rsp_valid), 0);
    check_flags("rst", 0, 0, 0);
    tick();

    // Directed arithmetic
    do_op("add_11_15", 11, 15, 0, 10, 1, 0);
    do_op("sub_8_4",    8,  4, 1,  4, 1, 1);
    do_op("sub_3_5",    3,  5, 1, 14, 0, 0);
    do_op("add_7_1",    7,  1, 0,  8, 0, 1);
    do_op("sub_8_1",    8,  1, 1,  7, 1, 1);
    do_op("sub_15_15", 15, 15, 1,  0, 1, 0);
    do_op("add_5_6",    5,  6, 0, 11, 0, 1);
    do_op("add_0_0",    0,  0, 0,  0, 0, 0);

    // Backpressure: 9+3 = 12, held while rsp_ready is low
    rsp_ready = 1'b0;
    av = 4'd9; bv = 4'd3; M = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (idx = 1; idx <= 20; idx++) begin
      tick();
      if (rsp_valid) break;
    end
    check("bp.latency", idx, WIDTH);
    av = 4'd1; bv = 4'd1; M = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp.rsp_valid", int'(rsp_valid), 1);
      check("bp.req_ready", int'(req_ready), 0);
      check_flags("bp", 12, 0, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("bp.req_ready_rise", int'(req_ready), 1);
    check("bp.rsp_valid_fall", int'(rsp_valid), 0);
    tick();
    check("bp.still_idle", int'(req_ready), 1);
    check_flags("bp.hold", 12, 0, 0);

    // Reset mid-CALC, previous result 11+15 = 10 / cout 1 visible beforehand
    do_op("pre_rst", 11, 15, 0, 10, 1, 0);
    av = 4'd6; bv = 4'd7; M = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst.req_ready", int'(req_ready), 1);
    check("mid_rst.rsp_valid", int'(rsp_valid), 0);
    check_flags("mid_rst", 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    do_op("post_rst", 2, 2, 0, 4, 0, 0);

    // Throughput with req_valid and rsp_ready held high
    idx = 0; resp = 0; last_acc = -1;
    av = tv_a[0]; bv = tv_b[0]; M = tv_m[0]; req_valid = 1'b1;
    for (int cyc = 0; cyc < 80 && resp < 4; cyc++) begin
      if (rsp_valid) begin
        check_flags($sformatf("tp%0d", resp), tv_r[resp], tv_c[resp], tv_o[resp]);
        resp++;
      end
      accept = req_ready && req_valid;
      if (accept) begin
        if (last_acc >= 0) check("tp.spacing", cyc - last_acc, WIDTH + 2);
        last_acc = cyc;
      end
      tick();
      if (accept) begin
        idx++;
        if (idx < 4) begin
          av = tv_a[idx]; bv = tv_b[idx]; M = tv_m[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    check("tp.responses", resp, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
